// File: rtl/bus_ctrl_seq_if.sv
// Handshake and strobe bundle between the instruction source and the bus sequencer.
// BUS_CTRL_HALT_EN adds the sticky halted status line.
interface bus_ctrl_seq_if #(
    parameter int NREG = 8,
    parameter int IW   = 9
);
    logic            run;
    logic [IW-1:0]   instr;
    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;
    logic            a_in;
    logic            g_in;
    logic            g_out;
    logic            din_out;
    logic            alu_sub;
    logic            busy;
    logic            done;
    logic            err;
`ifdef BUS_CTRL_HALT_EN
    logic            halted;

    modport master (output run, instr,
                    input  r_in, r_out, a_in, g_in, g_out, din_out, alu_sub, busy, done, err, halted);
    modport slave  (input  run, instr,
                    output r_in, r_out, a_in, g_in, g_out, din_out, alu_sub, busy, done, err, halted);
`else
    modport master (output run, instr,
                    input  r_in, r_out, a_in, g_in, g_out, din_out, alu_sub, busy, done, err);
    modport slave  (input  run, instr,
                    output r_in, r_out, a_in, g_in, g_out, din_out, alu_sub, busy, done, err);
`endif
endinterface

// File: rtl/bus_ctrl_seq.sv
// Multi-cycle control sequencer for the shared 16-bit tri-state datapath bus.
// Optional macro BUS_CTRL_HALT_EN turns opcode 111 into a sticky halt.
module bus_ctrl_seq #(
    parameter int NREG = 8,
    parameter int IW   = 9
) (
    input  logic          clk,
    input  logic          rst,
    bus_ctrl_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_T1   = 2'd1;
    localparam logic [1:0] ST_T2   = 2'd2;
    localparam logic [1:0] ST_T3   = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [IW-1:0]   r_ir;
    logic [2:0]      w_op;
    logic [2:0]      w_rx;
    logic [2:0]      w_ry;
    logic [NREG-1:0] w_rx_oh;
    logic [NREG-1:0] w_ry_oh;
    logic            w_op_ok;
    logic            w_illegal;
    logic            w_accept;
    logic            w_halt_now;

    function automatic logic [NREG-1:0] f_onehot(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'd1 << idx;
        return v[NREG-1:0];
    endfunction

    assign w_op    = r_ir[8:6];
    assign w_rx    = r_ir[5:3];
    assign w_ry    = r_ir[2:0];
    assign w_rx_oh = f_onehot(w_rx);
    assign w_ry_oh = f_onehot(w_ry);

    // Opcode legality; halt only exists when the feature is built in
    always_comb begin
        case (w_op)
            OP_MV, OP_MVI, OP_ADD, OP_SUB: w_op_ok = 1'b1;
`ifdef BUS_CTRL_HALT_EN
            OP_HALT:                       w_op_ok = 1'b1;
`endif
            default:                       w_op_ok = 1'b0;
        endcase
    end

    assign w_illegal  = !w_op_ok || (int'(w_rx) >= NREG) || (int'(w_ry) >= NREG);
    assign w_halt_now = (r_state == ST_T1) && !w_illegal && (w_op == OP_HALT);

`ifdef BUS_CTRL_HALT_EN
    logic r_halted;

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_now) begin
            r_halted <= 1'b1;
        end
    end

    assign bus.halted = r_halted;
    assign w_accept   = (r_state == ST_IDLE) && bus.run && !r_halted;
`else
    assign w_accept   = (r_state == ST_IDLE) && bus.run && !w_halt_now;
`endif

    // Next-state: only add/sub continue past T1
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_accept ? ST_T1 : ST_IDLE;
            ST_T1: begin
                if (!w_illegal && ((w_op == OP_ADD) || (w_op == OP_SUB))) begin
                    w_state_nxt = ST_T2;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_T2:   w_state_nxt = ST_T3;
            ST_T3:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and instruction register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ir <= bus.instr;
            end
        end
    end

    // Strobe decode from state and IR only, so reset silences the bus at once
    always_comb begin
        bus.r_in    = '0;
        bus.r_out   = '0;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.g_out   = 1'b0;
        bus.din_out = 1'b0;
        bus.alu_sub = 1'b0;
        bus.done    = 1'b0;
        bus.err     = 1'b0;
        bus.busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_T1: begin
                if (w_illegal) begin
                    bus.done = 1'b1;
                    bus.err  = 1'b1;
                end else begin
                    case (w_op)
                        OP_MV: begin
                            bus.r_out = w_ry_oh;
                            bus.r_in  = w_rx_oh;
                            bus.done  = 1'b1;
                        end
                        OP_MVI: begin
                            bus.din_out = 1'b1;
                            bus.r_in    = w_rx_oh;
                            bus.done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus.r_out = w_rx_oh;
                            bus.a_in  = 1'b1;
                        end
                        default: bus.done = 1'b1;
                    endcase
                end
            end
            ST_T2: begin
                bus.r_out   = w_ry_oh;
                bus.g_in    = 1'b1;
                bus.alu_sub = w_op[0];
            end
            ST_T3: begin
                bus.g_out = 1'b1;
                bus.r_in  = w_rx_oh;
                bus.done  = 1'b1;
            end
            default: bus.busy = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_bus_ctrl_seq.sv
// Randomized and directed bench for bus_ctrl_seq with a bus-level datapath
// model and an instruction-level reference of register contents.
module tb_bus_ctrl_seq;
    localparam int NREG = 8;
    localparam int IW   = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = 16'h0000;
    int          total = 0;
    int          bad   = 0;

    bus_ctrl_seq_if #(.NREG(NREG), .IW(IW)) bif ();
    bus_ctrl_seq #(.NREG(NREG), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    logic [15:0] dp_r  [NREG];
    logic [15:0] ref_r [NREG];
    logic [15:0] dp_a;
    logic [15:0] dp_g;
    logic [15:0] bus_v;

    // The 16-bit bus as seen by the registers: OR of every enabled driver
    always_comb begin
        bus_v = 16'h0000;
        for (int i = 0; i < NREG; i++) if (bif.r_out[i]) bus_v = bus_v | dp_r[i];
        if (bif.g_out)   bus_v = bus_v | dp_g;
        if (bif.din_out) bus_v = bus_v | din;
    end

    // Bus-attached registers and ALU react to the strobes
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) if (bif.r_in[i]) dp_r[i] <= bus_v;
        if (bif.a_in) dp_a <= bus_v;
        if (bif.g_in) dp_g <= bif.alu_sub ? (dp_a - bus_v) : (dp_a + bus_v);
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Driver/loader invariants, every cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            chk("one_driver", 32'($countones({bif.r_out, bif.g_out, bif.din_out}) <= 1), 32'd1);
            chk("one_loader", 32'($countones(bif.r_in) <= 1), 32'd1);
        end
    end

    function automatic logic [31:0] obs_vec();
        return {8'h00, bif.r_in, bif.r_out, bif.a_in, bif.g_in, bif.g_out,
                bif.din_out, bif.alu_sub, bif.busy, bif.done, bif.err};
    endfunction

    function automatic bit is_legal(input logic [8:0] ins);
        logic [2:0] op;
        bit op_ok;
        op = ins[8:6];
        op_ok = (op <= 3'd3);
`ifdef BUS_CTRL_HALT_EN
        if (op == 3'd7) op_ok = 1'b1;
`endif
        return op_ok && (int'(ins[5:3]) < NREG) && (int'(ins[2:0]) < NREG);
    endfunction

    function automatic int exp_len(input logic [8:0] ins);
        logic [2:0] op;
        op = ins[8:6];
        return (is_legal(ins) && (op == 3'd2 || op == 3'd3)) ? 3 : 1;
    endfunction

    // Expected strobes in cycle k after acceptance (k=0 is T1)
    function automatic logic [31:0] exp_vec(input logic [8:0] ins, input int k);
        logic [2:0] op, rx, ry;
        logic [7:0] ri, ro;
        logic ai, gi, go, di, su, dn, er;
        op = ins[8:6]; rx = ins[5:3]; ry = ins[2:0];
        ri = 8'h00; ro = 8'h00;
        ai = 1'b0; gi = 1'b0; go = 1'b0; di = 1'b0; su = 1'b0; dn = 1'b0; er = 1'b0;
        if (!is_legal(ins)) begin
            dn = 1'b1; er = 1'b1;
        end else if (op == 3'd0) begin
            ro[ry] = 1'b1; ri[rx] = 1'b1; dn = 1'b1;
        end else if (op == 3'd1) begin
            di = 1'b1; ri[rx] = 1'b1; dn = 1'b1;
        end else if (op == 3'd7) begin
            dn = 1'b1;
        end else if (k == 0) begin
            ro[rx] = 1'b1; ai = 1'b1;
        end else if (k == 1) begin
            ro[ry] = 1'b1; gi = 1'b1; su = op[0];
        end else begin
            go = 1'b1; ri[rx] = 1'b1; dn = 1'b1;
        end
        return {8'h00, ri, ro, ai, gi, go, di, su, 1'b1, dn, er};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle
    task automatic issue(input logic [8:0] ins, input logic [15:0] d, input bit keep);
        int n;
        logic [2:0] op, rx, ry;
        logic [15:0] a, b;
        op = ins[8:6]; rx = ins[5:3]; ry = ins[2:0];
        chk("idle_before", obs_vec(), 32'h0);
        bif.run = 1'b1; bif.instr = ins; din = d;
        @(posedge clk); @(negedge clk);
        bif.run = keep;
        n = exp_len(ins);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("op%0d_rx%0d_ry%0d_t%0d", op, rx, ry, k + 1), obs_vec(), exp_vec(ins, k));
            if (k < n - 1) @(negedge clk);
        end
        if (is_legal(ins) && op != 3'd7) begin
            a = ref_r[rx]; b = ref_r[ry];
            case (op)
                3'd0:    ref_r[rx] = b;
                3'd1:    ref_r[rx] = d;
                3'd2:    ref_r[rx] = a + b;
                default: ref_r[rx] = a - b;
            endcase
        end
        @(negedge clk);
        if (is_legal(ins) && op != 3'd7)
            chk($sformatf("reg_r%0d", rx), 32'(dp_r[rx]), 32'(ref_r[rx]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pre;
        logic [2:0]  rop;
        logic [8:0]  ins;
        bif.run = 1'b0; bif.instr = 9'h000;
        @(negedge clk);
        chk("in_reset", obs_vec(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_release", obs_vec(), 32'h0);

        for (int i = 0; i < NREG; i++) issue({3'b001, 3'(i), 3'b000}, 16'($urandom), 1'b0);

        issue(9'b001_010_000, 16'h0005, 1'b0);
        chk("mvi_r2", 32'(dp_r[2]), 32'h0005);
        issue(9'b001_001_000, 16'h0003, 1'b0);
        issue(9'b001_011_000, 16'h0004, 1'b0);
        issue(9'b010_001_011, 16'h0000, 1'b0);
        chk("add_r1", 32'(dp_r[1]), 32'h0007);
        issue(9'b001_001_000, 16'h0002, 1'b0);
        issue(9'b001_011_000, 16'h0005, 1'b0);
        issue(9'b011_001_011, 16'h0000, 1'b0);
        chk("sub_r1", 32'(dp_r[1]), 32'hFFFD);

        issue(9'b000_000_001, 16'h0000, 1'b1);
        issue(9'b010_010_010, 16'h0000, 1'b0);
        issue(9'b000_100_100, 16'h0000, 1'b0);
        issue(9'b101_000_000, 16'h0000, 1'b0);
`ifndef BUS_CTRL_HALT_EN
        issue(9'b111_000_000, 16'h0000, 1'b0);
`endif

        for (int t = 0; t < 60; t++) begin
`ifdef BUS_CTRL_HALT_EN
            rop = 3'($urandom_range(0, 6));
`else
            rop = 3'($urandom_range(0, 7));
`endif
            ins = {rop, 6'($urandom)};
            issue(ins, 16'($urandom), (t < 59) ? 1'($urandom) : 1'b0);
        end
        bif.run = 1'b0;

        // Abort an add in T2 with reset
        pre = dp_r[1];
        bif.run = 1'b1; bif.instr = 9'b010_001_011;
        @(posedge clk); @(negedge clk);
        bif.run = 1'b0;
        chk("abort_t1", obs_vec(), exp_vec(9'b010_001_011, 0));
        @(negedge clk);
        chk("abort_t2", obs_vec(), exp_vec(9'b010_001_011, 1));
        rst = 1'b0;
        #1;
        chk("abort_in_reset", obs_vec(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_release", obs_vec(), 32'h0);
        @(negedge clk);
        chk("abort_idle", obs_vec(), 32'h0);
        chk("abort_r1_kept", 32'(dp_r[1]), 32'(pre));

`ifdef BUS_CTRL_HALT_EN
        chk("halted_clear", 32'(bif.halted), 32'd0);
        issue(9'b111_000_000, 16'h0000, 1'b0);
        chk("halted_set", 32'(bif.halted), 32'd1);
        bif.run = 1'b1; bif.instr = 9'b001_000_000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halted_ignores_run", obs_vec(), 32'h0);
        end
        bif.run = 1'b0;
        rst = 1'b0;
        #1;
        chk("halted_reset", 32'(bif.halted), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(9'b001_000_000, 16'h00A5, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_ctrl_seq.md
Name: bus_ctrl_seq

Overview:
- Multi-cycle control sequencer for the shared 16-bit tri-state datapath bus.
- Sits directly upstream of the bus-attached registers: decodes one instruction word and drives their per-register load (R_in) and tri-state drive (R_out) strobes, plus strobes for the ALU operand register A, the result register G and the external-data driver.
- Guarantees at most one bus driver per cycle and signals completion with a one-cycle done pulse.

Parameters:
- NREG, 8, number of general registers R0..R(NREG-1) controlled; 2..8 (register fields are 3 bits).
- IW, 9, instruction word width; opcode in bits [8:6], rx in [5:3], ry in [2:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- run  in  1  start request; sampled only in IDLE
- instr  in  IW  instruction word; sampled into IR in the same cycle run is accepted
- r_in  out  NREG  one-hot load strobes for R0..R(NREG-1)
- r_out  out  NREG  one-hot bus-drive strobes for R0..R(NREG-1)
- a_in  out  1  load ALU operand register A from bus
- g_in  out  1  load G from ALU result
- g_out  out  1  G drives bus
- din_out  out  1  external data word drives bus
- alu_sub  out  1  ALU subtracts (0 = add)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the final cycle of an instruction
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode or out-of-range register field

Behaviour:
- Registers: state (IDLE, T1, T2, T3) and IR[IW-1:0]. All strobes are combinational decodes of state and IR only. run and instr feed only next-state and IR-load logic.
- Reset (rst=0, async): state=IDLE, IR=0. All outputs 0 while in reset and in the first cycle after release.
- Reset mid-instruction: aborts immediately. No further strobes are issued and a partial add/sub leaves Rx unwritten.
- IDLE: if run=1, IR<=instr and state<=T1. Otherwise hold. run is ignored in all other states; no queueing.
- Opcodes:
  - 000 mv: T1 asserts r_out[ry], r_in[rx], done. Then IDLE.
  - 001 mvi: T1 asserts din_out, r_in[rx], done. Then IDLE.
  - 010 add: T1 r_out[rx], a_in. T2 r_out[ry], g_in, alu_sub=0. T3 g_out, r_in[rx], done. Then IDLE.
  - 011 sub: same as add, with alu_sub=1 in T2.
  - 100..110, or any rx/ry >= NREG: T1 asserts done and err with no other strobe. Then IDLE.
- Latency: mv/mvi complete 2 cycles after run is accepted (IDLE + T1); add/sub complete in 4.
- Back-to-back: run may be held high. The next instruction is sampled in the IDLE cycle immediately after done, so throughput is 1 instruction per 2 or 4 cycles.
- mv with rx==ry is legal and asserts the same register's r_out and r_in together.
- Invariant: popcount(r_out) + g_out + din_out <= 1 in every cycle. popcount(r_in) <= 1.
- busy=1 exactly in T1, T2 and T3.

Optional Feature:
- Macro: BUS_CTRL_HALT_EN.
- Defined: opcode 111 = halt. T1 asserts done, then a sticky halted flag is set, reported on an extra output port halted. While halted, run is ignored and state stays IDLE. Only reset clears it (reset value 0).
- Undefined: opcode 111 is illegal (done+err), and the halted port does not exist.

Test Plan:
- Reset: rst=0 mid-add in T2 -> all strobes 0 immediately; after release, state IDLE, no r_in pulse, busy=0.
- mvi R2 (instr=9'b001_010_000), run=1 one cycle -> next cycle din_out=1, r_in=8'b0000_0100, done=1; with the bus driven to 16'h0005, R2 reads back 5.
- add R1,R3 (9'b010_001_011) with R1=3, R3=4 -> T1 r_out[1]+a_in; T2 r_out[3]+g_in, alu_sub=0; T3 g_out+r_in[1]+done; R1 reads 7.
- sub R1,R3 with R1=2, R3=5 -> R1=16'hFFFD (wrap), alu_sub=1 only in T2.
- run held high over mv R0,R1 then add R2,R2 -> done pulses 2 and 4 cycles later; bus-driver invariant never violated (checked every cycle).
- Illegal op 9'b101_000_000 -> done=1, err=1 in T1, no other strobe. With BUS_CTRL_HALT_EN, op 111 -> halted=1, and subsequent run is ignored until reset.
